i2cmb_cmd_sequencer: RTL and testbench
======================================

Name: i2cmb_cmd_sequencer

Overview:
- Synthesizable Wishbone master that sits directly upstream of the i2cmb DUT (iicmb_m_wb) and drives its four byte registers.
- Accepts byte-level I2C operations (start, stop, write, read ack/nack, set bus, wait) over a valid/ready command port.
- Expands each operation into the required CSR/DPR/CMDR register transactions, waits for completion, and returns the CMDR status plus any read data on a response port.
- Gives the env a hardware stimulus path and gives the predictor a checkable reference sequence.

Parameters:
- TIMEOUT_CYCLES, 4096: clk_i cycles allowed in WAIT_DONE before a timeout is declared; 0 disables the timeout.
- CSR_INIT, 8'hC0: value written to CSR after reset (E=1, IE=1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  sequencer accepts command this cycle
- cmd_op_i  in  3  op code using CMDR encoding: 000 wait, 001 write, 010 read-ack, 011 read-nack, 100 start, 101 stop, 110 set-bus
- cmd_data_i  in  8  byte for write / wait count / bus id
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_data_o  out  8  DPR byte for reads, else 0
- rsp_status_o  out  5  {TIMEOUT, DON, NAK, AL, ERR}
- busy_o  out  1  high whenever the FSM is not in IDLE
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  2  0=CSR, 1=DPR, 2=CMDR, 3=FSMR
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  DUT interrupt, level

Behaviour:
- Reset values: all outputs 0; FSM state INIT; timeout counter 0.
- Wishbone rules:
  - One transfer at a time; cyc/stb/we/adr/dat are registered and held stable until the cycle wb_ack_i=1.
  - cyc/stb drop on the cycle after ack; no back-to-back strobes.
- FSM states and transitions:
  - INIT: write CSR_INIT to CSR, then go to IDLE.
  - IDLE: cmd_ready_o=1. On valid&ready, latch op and data.
    - Ops 000, 001, 110 go to WR_DPR.
    - All other ops go to WR_CMDR.
  - WR_DPR: write cmd_data_i to DPR, then go to WR_CMDR.
  - WR_CMDR: write {5'b0, op} to CMDR, then go to WAIT_DONE.
  - WAIT_DONE: wait for irq_i=1, then go to RD_CMDR. The timeout counter increments every cycle in this state.
  - RD_CMDR: read CMDR; status[3:0] = dat_i[7:4]. Reading CMDR clears the DUT irq.
    - Read ops with DON=1 go to RD_DPR.
    - Otherwise go to RESP.
  - RD_DPR: read DPR into rsp_data, then go to RESP.
  - RESP: rsp_valid_o=1 for one cycle, then go to IDLE.
- Latency: write op with zero-wait-state ack is at least 7 cycles from accept to rsp_valid_o, excluding I2C bus time.
- cmd_ready_o is low in every state except IDLE. A command presented while busy is held by the sender; it is never dropped.
- Timeout: counter reaches TIMEOUT_CYCLES in WAIT_DONE → status=5'b10000 and rsp_data=0, go to RESP. The DUT is left as-is; the next command proceeds normally.
- irq_i already high on entry to WAIT_DONE: advance on the next cycle.
- NAK, AL and ERR are reported verbatim; the sequencer never retries.
- Reset asserted mid-transfer: cyc/stb drop immediately and the FSM returns to INIT. The in-flight command is lost and produces no response.
- rsp_status_o and rsp_data_o hold their values until the next RESP.

Optional Feature:
- Macro: I2CMB_SEQ_POLL_EN.
- Defined:
  - irq_i is ignored and CSR_INIT bit 6 is forced to 0.
  - WAIT_DONE issues CMDR reads repeatedly until any of dat_i[7:4] is nonzero, then uses that read as the RD_CMDR result.
  - The timeout still applies.
- Undefined: interrupt-driven operation as described in Behaviour.

Test Plan:
- Reset release → first Wishbone write is adr=0, dat=8'hC0, before cmd_ready_o rises.
- Set-bus with data 8'h05 → DPR←05, CMDR←06; DUT returns CMDR=8'h80 → rsp_status=5'b01000, rsp_data=0.
- Start, write 8'h44, stop to a responding slave → three responses, each DON only. DPR write data 8'h44 is visible on wb_dat_o.
- Read-nack where the slave returns 8'hA5 → RD_CMDR then RD_DPR; rsp_data=8'hA5, status=01000.
- Write to an absent address → CMDR=8'h40 → status=00100, no DPR read.
- TIMEOUT_CYCLES=16 with irq_i held low → response exactly 16 cycles after entering WAIT_DONE, status=10000. Next command is accepted.

Source files
------------

// File: rtl/i2cmb_cmd_sequencer.sv
// i2cmb_cmd_sequencer: Wishbone master that turns byte-level I2C operations
// into iicmb register sequences (CSR/DPR/CMDR) and reports the CMDR status.
// Optional build: define I2CMB_SEQ_POLL_EN to poll CMDR for completion instead
// of waiting on irq_i (CSR interrupt enable is then left cleared).
module i2cmb_cmd_sequencer #(
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  CSR_INIT       = 8'hC0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic [4:0] rsp_status_o,
    output logic       busy_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [1:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,
    input  logic       irq_i
);

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;

`ifdef I2CMB_SEQ_POLL_EN
    localparam logic [7:0] CSR_VAL = CSR_INIT & 8'hBF;
    wire unused_irq = irq_i;
`else
    localparam logic [7:0] CSR_VAL = CSR_INIT;
`endif

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_DPR, S_WR_CMDR, S_WAIT_DONE, S_RD_CMDR, S_RD_DPR, S_RESP
    } state_e;

    state_e state_q, state_d;

    logic          wb_cyc_q, wb_cyc_d;
    logic          wb_stb_q, wb_stb_d;
    logic          wb_we_q, wb_we_d;
    logic [1:0]    wb_adr_q, wb_adr_d;
    logic [7:0]    wb_dat_q, wb_dat_d;
    logic [2:0]    op_q, op_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    stat_q, stat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [4:0]    rsp_status_q, rsp_status_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic          bus_req, bus_we;
    logic [1:0]    bus_adr;
    logic [7:0]    bus_dat;

    // A transfer completes on the cycle ack arrives while our cycle is open.
    logic xfer_done;
    logic is_read;
    logic tmo_hit;
    assign xfer_done = wb_cyc_q & wb_ack_i;
    assign is_read   = (op_q[2:1] == 2'b01);
    assign tmo_hit   = TMO_EN && (tmo_q >= TMO_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next-state: bus states advance on ack, WAIT_DONE on irq/poll or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (xfer_done) state_d = S_IDLE;
            S_IDLE:    if (cmd_valid_i)
                           state_d = (cmd_op_i == 3'b000 || cmd_op_i == 3'b001 ||
                                      cmd_op_i == 3'b110) ? S_WR_DPR : S_WR_CMDR;
            S_WR_DPR:  if (xfer_done) state_d = S_WR_CMDR;
            S_WR_CMDR: if (xfer_done) state_d = S_WAIT_DONE;
`ifdef I2CMB_SEQ_POLL_EN
            S_WAIT_DONE: begin
                if (xfer_done && wb_dat_i[7:4] != 4'h0)
                    state_d = (is_read && wb_dat_i[7]) ? S_RD_DPR : S_RESP;
                else if (!wb_cyc_q && tmo_hit)
                    state_d = S_RESP;
            end
`else
            S_WAIT_DONE: begin
                if (irq_i)        state_d = S_RD_CMDR;
                else if (tmo_hit) state_d = S_RESP;
            end
`endif
            S_RD_CMDR: if (xfer_done) state_d = (is_read && wb_dat_i[7]) ? S_RD_DPR : S_RESP;
            S_RD_DPR:  if (xfer_done) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    // Outputs/datapath next values: one Wishbone transfer per bus state, status capture, response load.
    always_comb begin
        wb_cyc_d     = wb_cyc_q;
        wb_stb_d     = wb_stb_q;
        wb_we_d      = wb_we_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;
        op_d         = op_q;
        data_d       = data_q;
        stat_d       = stat_q;
        tmo_d        = '0;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        ready_d      = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_adr      = ADR_CSR;
        bus_dat      = 8'h00;

        case (state_q)
            S_INIT:      begin bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_CSR;  bus_dat = CSR_VAL; end
            S_IDLE:      if (cmd_valid_i) begin op_d = cmd_op_i; data_d = cmd_data_i; end
            S_WR_DPR:    begin bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_DPR;  bus_dat = data_q; end
            S_WR_CMDR:   begin bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_CMDR; bus_dat = {5'b0, op_q}; end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + 1'b1;
`ifdef I2CMB_SEQ_POLL_EN
                bus_req = 1'b1; bus_adr = ADR_CMDR;
`endif
            end
            S_RD_CMDR:   begin bus_req = 1'b1; bus_adr = ADR_CMDR; end
            S_RD_DPR:    begin bus_req = 1'b1; bus_adr = ADR_DPR; end
            default:     ;
        endcase

        // Drop the cycle after ack; launch only when idle and staying in this state,
        // which leaves one dead cycle between strobes.
        if (xfer_done) begin
            wb_cyc_d = 1'b0;
            wb_stb_d = 1'b0;
            wb_we_d  = 1'b0;
        end else if (!wb_cyc_q && bus_req && state_d == state_q) begin
            wb_cyc_d = 1'b1;
            wb_stb_d = 1'b1;
            wb_we_d  = bus_we;
            wb_adr_d = bus_adr;
            wb_dat_d = bus_dat;
        end

        if (xfer_done && !wb_we_q && wb_adr_q == ADR_CMDR)
            stat_d = wb_dat_i[7:4];

        // Response registers change only when entering RESP and hold otherwise.
        if (state_d == S_RESP && state_q != S_RESP) begin
            rsp_valid_d = 1'b1;
            if (state_q == S_RD_DPR) begin
                rsp_status_d = {1'b0, stat_q};
                rsp_data_d   = wb_dat_i;
            end else if (xfer_done) begin
                rsp_status_d = {1'b0, wb_dat_i[7:4]};
                rsp_data_d   = 8'h00;
            end else begin
                rsp_status_d = 5'b10000;
                rsp_data_d   = 8'h00;
            end
        end
    end

    // Datapath and output registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_cyc_q     <= 1'b0;
            wb_stb_q     <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_adr_q     <= 2'd0;
            wb_dat_q     <= 8'h00;
            op_q         <= 3'd0;
            data_q       <= 8'h00;
            stat_q       <= 4'h0;
            tmo_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 5'd0;
            rsp_data_q   <= 8'h00;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wb_cyc_q     <= wb_cyc_d;
            wb_stb_q     <= wb_stb_d;
            wb_we_q      <= wb_we_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            op_q         <= op_d;
            data_q       <= data_d;
            stat_q       <= stat_d;
            tmo_q        <= tmo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_data_o   = rsp_data_q;
    assign wb_cyc_o     = wb_cyc_q;
    assign wb_stb_o     = wb_stb_q;
    assign wb_we_o      = wb_we_q;
    assign wb_adr_o     = wb_adr_q;
    assign wb_dat_o     = wb_dat_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench for i2cmb_cmd_sequencer: an iicmb register-slave model answers the
// Wishbone bus, a queue model predicts bus transactions and responses.
module tb_i2cmb_cmd_sequencer;

    localparam int         TMO     = 16;
    localparam logic [7:0] CSR_EXP = 8'hC0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       wb_ack = 1'b0;
    logic [7:0] wb_din = 8'h00;
    logic       irq = 1'b0;

    logic       cmd_ready_o, rsp_valid_o, busy_o;
    logic [7:0] rsp_data_o;
    logic [4:0] rsp_status_o;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0] wb_adr_o;
    logic [7:0] wb_dat_o;

    i2cmb_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .CSR_INIT(CSR_EXP)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
        .busy_o(busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_din),
        .wb_ack_i(wb_ack), .irq_i(irq)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [1:0] adr; logic [7:0] dat; } bus_t;
    typedef struct { logic [4:0] st; logic [7:0] dat; bit tmo; } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    int checks = 0, errors = 0;
    int cyc_n = 0;
    int ack_delay = 0, irq_delay = 0;
    logic [7:0] cmdr_val = 8'h80, rd_byte = 8'h00;
    int rsp_seen = 0, n_acks = 0;
    logic [4:0] last_st = 5'd0;
    logic [7:0] last_dat = 8'h00;
    logic [1:0] first_adr = 2'd3;
    logic [7:0] first_dat = 8'h00;
    bit ready_early = 0;
    logic [7:0] last_dpr_w = 8'h00, last_cmdr_w = 8'h00;
    int accept_cyc = 0, tmo_due = 0;
    bit lat_chk = 0;

    // slave/compare process state
    bit   pend = 0, prev_rsp = 0;
    int   wcnt = 0, irq_cnt = -1;
    bus_t cap, b;
    rsp_t r;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: derive the register sequence and response for an accepted op.
    task automatic model_accept(input logic [2:0] op, input logic [7:0] d);
        bit rd;
        rsp_t e;
        rd = (op == 3'd2 || op == 3'd3);
        if (op == 3'd0 || op == 3'd1 || op == 3'd6) exp_bus.push_back('{1'b1, 2'd1, d});
        exp_bus.push_back('{1'b1, 2'd2, {5'b0, op}});
        if (irq_delay < 0) begin
            e = '{5'b10000, 8'h00, 1'b1};
        end else begin
            exp_bus.push_back('{1'b0, 2'd2, 8'h00});
            if (rd && cmdr_val[7]) exp_bus.push_back('{1'b0, 2'd1, 8'h00});
            e = '{{1'b0, cmdr_val[7:4]}, (rd && cmdr_val[7]) ? rd_byte : 8'h00, 1'b0};
        end
        exp_rsp.push_back(e);
    endtask

    // One compare/slave process, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            wb_ack = 1'b0; irq = 1'b0; pend = 0; wcnt = 0; irq_cnt = -1; prev_rsp = 0;
            last_st = 5'd0; last_dat = 8'h00;
        end else begin
            chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
            chk("ready_busy_excl", cmd_ready_o & busy_o, 0);
            if (cmd_ready_o && n_acks == 0) ready_early = 1;

            if (rsp_valid_o) begin
                chk("rsp_pulse", prev_rsp, 0);
                if (exp_rsp.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_status", rsp_status_o, r.st);
                    chk("rsp_data", rsp_data_o, r.dat);
                    if (r.tmo) chk("tmo_latency", cyc_n, tmo_due);
                end
                if (lat_chk) begin chk("wr_latency_min", (cyc_n - accept_cyc) >= 7, 1); lat_chk = 0; end
                last_st = rsp_status_o; last_dat = rsp_data_o;
                rsp_seen++;
            end else begin
                chk("rsp_hold", {rsp_status_o, rsp_data_o}, {last_st, last_dat});
            end
            prev_rsp = rsp_valid_o;

            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) begin irq = 1'b1; irq_cnt = -1; end
            end

            if (wb_ack) begin
                wb_ack = 1'b0;
                chk("cyc_drop_after_ack", wb_cyc_o, 0);
            end else if (wb_cyc_o) begin
                if (!pend) begin
                    pend = 1; wcnt = 0; cap = '{wb_we_o, wb_adr_o, wb_dat_o};
                end else begin
                    chk("bus_stable", {wb_we_o, wb_adr_o, wb_dat_o}, {cap.we, cap.adr, cap.dat});
                end
                if (wcnt >= ack_delay) begin
                    wb_ack = 1'b1; pend = 0;
                    if (n_acks == 0) begin first_adr = wb_adr_o; first_dat = wb_dat_o; end
                    n_acks++;
                    if (exp_bus.size() == 0) chk("unexpected_bus", 1, 0);
                    else begin
                        b = exp_bus.pop_front();
                        chk("bus_we", wb_we_o, b.we);
                        chk("bus_adr", wb_adr_o, b.adr);
                        if (b.we) chk("bus_wdat", wb_dat_o, b.dat);
                    end
                    wb_din = 8'h00;
                    if (wb_we_o && wb_adr_o == 2'd1) last_dpr_w = wb_dat_o;
                    if (wb_we_o && wb_adr_o == 2'd2) begin
                        last_cmdr_w = wb_dat_o;
                        if (irq_delay < 0) begin irq_cnt = -1; tmo_due = cyc_n + 1 + TMO; end
                        else if (irq_delay == 0) irq = 1'b1;
                        else irq_cnt = irq_delay;
                    end
                    if (!wb_we_o && wb_adr_o == 2'd2) begin wb_din = cmdr_val; irq = 1'b0; end
                    if (!wb_we_o && wb_adr_o == 2'd1) wb_din = rd_byte;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready_o && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready_o) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        accept_cyc = cyc_n + 1;
        model_accept(op, d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_seen < target && n < 300) begin @(negedge clk); n++; end
        if (rsp_seen < target) chk("rsp_wait_timeout", rsp_seen, target);
    endtask

    task automatic cfg(input logic [7:0] cm, input logic [7:0] rb, input int irqd, input int ackd);
        cmdr_val = cm; rd_byte = rb; irq_delay = irqd; ack_delay = ackd;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready_o && n < 100) begin @(negedge clk); n++; end
        chk("ready_after_reset", cmd_ready_o, 1);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, cmd_ready_o, rsp_valid_o, busy_o}, 0);
        chk("reset_data", {wb_dat_o, rsp_data_o, rsp_status_o}, 0);
        exp_bus.push_back('{1'b1, 2'd0, CSR_EXP});
        rst_n = 1'b1;
        wait_ready();
        chk("first_csr_write", {first_adr, first_dat}, {2'd0, 8'hC0});
        chk("ready_not_before_csr", ready_early, 0);

        // set-bus 05
        cfg(8'h80, 8'h00, 2, 1);
        base = rsp_seen; send(3'd6, 8'h05); wait_rsp(base + 1);
        chk("setbus_status", last_st, 5'b01000);
        chk("setbus_data", last_dat, 8'h00);
        chk("setbus_dpr", last_dpr_w, 8'h05);
        chk("setbus_cmdr", last_cmdr_w, 8'h06);

        // start, write 44, stop
        cfg(8'h80, 8'h00, 0, 0);
        base = rsp_seen; send(3'd4, 8'h00); wait_rsp(base + 1);
        chk("start_status", last_st, 5'b01000);
        lat_chk = 1;
        send(3'd1, 8'h44); wait_rsp(base + 2);
        chk("write_status", last_st, 5'b01000);
        chk("write_dpr", last_dpr_w, 8'h44);
        send(3'd5, 8'h00); wait_rsp(base + 3);
        chk("stop_status", last_st, 5'b01000);

        // read-nack returns A5
        cfg(8'h80, 8'hA5, 3, 2);
        base = rsp_seen; send(3'd3, 8'h00); wait_rsp(base + 1);
        chk("rdnack_status", last_st, 5'b01000);
        chk("rdnack_data", last_dat, 8'hA5);

        // absent address: NAK, no DPR read
        cfg(8'h40, 8'h5A, 1, 0);
        base = rsp_seen; send(3'd1, 8'hA0); wait_rsp(base + 1);
        chk("nak_status", last_st, 5'b00100);
        chk("nak_data", last_dat, 8'h00);

        // read-ack losing arbitration; wait op reporting ERR
        cfg(8'h20, 8'h77, 0, 1);
        base = rsp_seen; send(3'd2, 8'h00); wait_rsp(base + 1);
        chk("al_status", last_st, 5'b00010);
        chk("al_data", last_dat, 8'h00);
        cfg(8'h10, 8'h00, 4, 0);
        base = rsp_seen; send(3'd0, 8'h03); wait_rsp(base + 1);
        chk("err_status", last_st, 5'b00001);

        // timeout with irq held low
        cfg(8'h80, 8'h00, -1, 0);
        base = rsp_seen; send(3'd1, 8'h3C); wait_rsp(base + 1);
        chk("tmo_status", last_st, 5'b10000);
        chk("tmo_data", last_dat, 8'h00);

        // next commands proceed; second one is held while busy
        cfg(8'h80, 8'h00, 1, 0);
        base = rsp_seen; send(3'd4, 8'h00); send(3'd5, 8'h00); wait_rsp(base + 2);
        chk("after_tmo_status", last_st, 5'b01000);

        // reset during a DPR write: bus drops at once, no response
        cfg(8'h80, 8'h00, 0, 6);
        base = rsp_seen;
        cmd_op = 3'd1; cmd_data = 8'h99; cmd_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
            @(negedge clk); cmd_valid = 1'b0;
            n = 0;
            while (!(wb_cyc_o && wb_adr_o == 2'd1) && n < 50) begin @(negedge clk); n++; end
            chk("dpr_cycle_seen", wb_cyc_o, 1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
        exp_bus.delete(); exp_rsp.delete();
        ack_delay = 0;
        repeat (2) @(negedge clk);
        exp_bus.push_back('{1'b1, 2'd0, CSR_EXP});
        rst_n = 1'b1;
        wait_ready();
        chk("no_rsp_after_reset", rsp_seen, base);
        chk("reset_rsp_cleared", {last_st, last_dat}, 0);

        cfg(8'h80, 8'h00, 0, 0);
        base = rsp_seen; send(3'd4, 8'h00); wait_rsp(base + 1);
        chk("post_reset_status", last_st, 5'b01000);
        repeat (3) @(negedge clk);
        chk("bus_queue_drained", exp_bus.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
